// File: rtl/bin_2_bcd_seq_if.sv
// Handshake and result bus for the sequential binary-to-BCD converter.
// The requester uses the master modport and the converter uses the slave modport.
interface bin_2_bcd_seq_if #(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
);
   logic                  START_i;
   logic [BIN_W-1:0]      IN_i;
   logic [4*DIGITS-1:0]   OUT_o;
   logic                  BUSY_o;
   logic                  DONE_o;
   logic                  OVF_o;

   modport master (output START_i, IN_i, input OUT_o, BUSY_o, DONE_o, OVF_o);
   modport slave  (input START_i, IN_i, output OUT_o, BUSY_o, DONE_o, OVF_o);
endinterface

// File: rtl/bin_2_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// It has a start/busy/done handshake, a held result, and a sticky overflow flag.
// Optional macro BIN_2_BCD_BLANK_EN: leading zero digits of the loaded result
// become 4'hF, which the 7-segment decoder shows as blank. Digit 0 is never blanked.
module bin_2_bcd_seq #(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
) (
   input  logic             CLK_i,
   input  logic             RST_N_i,
   bin_2_bcd_seq_if.slave   bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_nxt;
   logic               load;
   logic [BIN_W-1:0]   bin_q, bin_nxt;
   logic [BW-1:0]      bcd_q, bcd_nxt, adj, out_nxt;
   logic               carry_q;
   logic [CW-1:0]      count_q;
   logic [BW-1:0]      out_q;
   logic               ovf_q, done_q;
   logic [BW+BIN_W-1:0] sh;

   assign bus.OUT_o  = out_q;
   assign bus.OVF_o  = ovf_q;
   assign bus.DONE_o = done_q;
   assign bus.BUSY_o = (state == SHIFT);

   // State register.
   always_ff @(posedge CLK_i or negedge RST_N_i) begin
      if (!RST_N_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic. A start request is accepted in IDLE and in DONE, so
   // conversions can run back to back.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      unique case (state)
         IDLE: if (bus.START_i) begin
            load      = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: if (count_q == CW'(1)) state_nxt = DONE;
         DONE: begin
            load      = bus.START_i;
            state_nxt = bus.START_i ? SHIFT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Add 3 to each digit that is 5 or more, then shift {bcd, bin} left by one bit.
   // The bit that leaves the top digit is the decimal carry worth 10^DIGITS.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      sh      = {adj, bin_q} << 1;
      bcd_nxt = sh[BW+BIN_W-1:BIN_W];
      bin_nxt = sh[BIN_W-1:0];
   end

   // Formats the result that DONE loads into the output register.
   always_comb begin
      out_nxt = bcd_q;
`ifdef BIN_2_BCD_BLANK_EN
      begin
         logic lead;
         lead = 1'b1;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && bcd_q[4*i +: 4] == 4'd0) out_nxt[4*i +: 4] = 4'hF;
            else                                lead = 1'b0;
         end
      end
`endif
   end

   // Working registers: load on an accepted start, shift once per SHIFT cycle.
   always_ff @(posedge CLK_i or negedge RST_N_i) begin
      if (!RST_N_i) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
      end else if (load) begin
         bin_q   <= bus.IN_i;
         bcd_q   <= '0;
         carry_q <= 1'b0;
         count_q <= CW'(BIN_W);
      end else if (state == SHIFT) begin
         bin_q   <= bin_nxt;
         bcd_q   <= bcd_nxt;
         carry_q <= carry_q | adj[BW-1];
         count_q <= count_q - CW'(1);
      end
   end

   // Result registers: updated only when leaving DONE. DONE_o marks the update.
   always_ff @(posedge CLK_i or negedge RST_N_i) begin
      if (!RST_N_i) begin
         out_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == DONE);
         if (state == DONE) begin
            out_q <= out_nxt;
            ovf_q <= carry_q;
         end
      end
   end
endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// Self-checking bench for bin_2_bcd_seq. It runs DIGITS=4 and DIGITS=3 instances in parallel.
module tb_bin_2_bcd_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bin_2_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) b4();
   bin_2_bcd_seq_if #(.BIN_W(12), .DIGITS(3)) b3();

   bin_2_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut4 (.CLK_i(clk), .RST_N_i(rst_n), .bus(b4));
   bin_2_bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (.CLK_i(clk), .RST_N_i(rst_n), .bus(b3));

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] prev4 = 16'h0;

   typedef struct {
      int          val;
      logic [15:0] e4;
      bit          o4;
      logic [15:0] e3;
      bit          o3;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Leading-zero blanking as seen on the 7-segment path (only in the blanking build).
   function automatic logic [15:0] blank(input logic [15:0] r, input int d);
      logic [15:0] x = r;
`ifdef BIN_2_BCD_BLANK_EN
      bit lead = 1'b1;
      for (int i = d - 1; i >= 1; i--)
         if (lead && x[4*i +: 4] == 4'd0) x[4*i +: 4] = 4'hF;
         else lead = 1'b0;
`endif
      return x;
   endfunction

   // Reference model: decimal digits of v mod 10^d, with overflow if v > 10^d - 1.
   function automatic logic [15:0] model(input int v, input int d, output bit ovf);
      int p = 1;
      int m;
      logic [15:0] r = 16'h0;
      for (int i = 0; i < d; i++) p *= 10;
      ovf = (v > p - 1);
      m = v % p;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return blank(r, d);
   endfunction

   task automatic drive(input bit s, input logic [11:0] v);
      b4.START_i = s; b4.IN_i = v;
      b3.START_i = s; b3.IN_i = v;
   endtask

   task automatic convert(input logic [11:0] v, input logic [15:0] e4, input bit o4,
                          input logic [15:0] e3, input bit o3);
      int e, busy;
      @(negedge clk); drive(1'b1, v);
      @(posedge clk);
      @(negedge clk); drive(1'b0, 12'($urandom));
      e = 0; busy = 0;
      while (!b4.DONE_o && e < 40) begin
         if (e == 5) chk("hold_out", 32'(b4.OUT_o), 32'(prev4));
         if (b4.BUSY_o) busy++;
         @(negedge clk); e++;
      end
      chk("latency", e, 13);
      chk("busy_cycles", busy, 12);
      chk("out4", 32'(b4.OUT_o), 32'(e4));
      chk("ovf4", 32'(b4.OVF_o), 32'(o4));
      chk("done3", 32'(b3.DONE_o), 32'd1);
      chk("out3", 32'(b3.OUT_o), 32'(e3));
      chk("ovf3", 32'(b3.OVF_o), 32'(o3));
      prev4 = e4;
      @(negedge clk);
      chk("done_pulse", 32'(b4.DONE_o), 32'd0);
   endtask

   initial begin
      int e, n;
      bit o4, o3;
      logic [15:0] x4, x3;
      logic [11:0] v;

      tbl[0] = '{0,    16'h0000, 1'b0, 16'h000, 1'b0};
      tbl[1] = '{4095, 16'h4095, 1'b0, 16'h095, 1'b1};
      tbl[2] = '{1234, 16'h1234, 1'b0, 16'h234, 1'b1};
      tbl[3] = '{999,  16'h0999, 1'b0, 16'h999, 1'b0};
      tbl[4] = '{1000, 16'h1000, 1'b0, 16'h000, 1'b1};
      tbl[5] = '{7,    16'h0007, 1'b0, 16'h007, 1'b0};

      drive(1'b0, 12'h0);
      repeat (3) @(negedge clk);
      chk("rst_out", 32'(b4.OUT_o), 32'd0);
      chk("rst_busy", 32'(b4.BUSY_o), 32'd0);
      chk("rst_done", 32'(b4.DONE_o), 32'd0);
      chk("rst_ovf", 32'(b4.OVF_o), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(b4.BUSY_o), 32'd0);

      // Directed table.
      for (int i = 0; i < 6; i++)
         convert(12'(tbl[i].val), blank(tbl[i].e4, 4), tbl[i].o4, blank(tbl[i].e3, 3), tbl[i].o3);

      // Randomized values checked against the arithmetic model.
      repeat (30) begin
         v  = 12'($urandom_range(0, 4095));
         x4 = model(int'(v), 4, o4);
         x3 = model(int'(v), 3, o3);
         convert(v, x4, o4, x3, o3);
      end

      // A second start while busy is ignored.
      @(negedge clk); drive(1'b1, 12'd100);
      @(posedge clk);
      @(negedge clk); drive(1'b0, 12'd0);
      repeat (3) @(negedge clk);
      drive(1'b1, 12'd55);
      @(negedge clk); drive(1'b0, 12'd0);
      e = 0;
      while (!b4.DONE_o && e < 40) begin @(negedge clk); e++; end
      x4 = model(100, 4, o4);
      chk("ign_out", 32'(b4.OUT_o), 32'(x4));
      chk("ign_done", 32'(b4.DONE_o), 32'd1);
      prev4 = x4;
      n = 0;
      repeat (30) begin @(negedge clk); if (b4.DONE_o) n++; end
      chk("ign_single", n, 0);
      chk("ign_hold", 32'(b4.OUT_o), 32'(x4));

      // Start held high: one result every 13 cycles.
      @(negedge clk); drive(1'b1, 12'd7);
      e = 0;
      while (!b4.DONE_o && e < 40) begin @(negedge clk); e++; end
      chk("cont_first", e, 14);
      x4 = model(7, 4, o4);
      for (int k = 0; k < 3; k++) begin
         e = 0;
         do begin @(negedge clk); e++; end while (!b4.DONE_o && e < 40);
         chk("cont_period", e, 13);
         chk("cont_out", 32'(b4.OUT_o), 32'(x4));
      end
      drive(1'b0, 12'd0);
      repeat (30) @(negedge clk);
      prev4 = x4;

      // Reset during SHIFT aborts the conversion.
      drive(1'b1, 12'd4095);
      @(posedge clk);
      @(negedge clk); drive(1'b0, 12'd0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_out4", 32'(b4.OUT_o), 32'd0);
      chk("arst_out3", 32'(b3.OUT_o), 32'd0);
      chk("arst_busy", 32'(b4.BUSY_o), 32'd0);
      chk("arst_ovf", 32'(b4.OVF_o), 32'd0);
      n = 0;
      repeat (5) begin @(negedge clk); if (b4.DONE_o) n++; end
      rst_n = 1'b1;
      repeat (20) begin @(negedge clk); if (b4.DONE_o) n++; end
      chk("arst_no_done", n, 0);
      prev4 = 16'h0;
      x4 = model(1234, 4, o4);
      x3 = model(1234, 3, o3);
      convert(12'd1234, x4, o4, x3, o3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
